// File: rtl/mmio_tx_fifo_pkg.sv
// Register offsets, STATUS/CTRL bit positions and the STATUS word packer shared by the
// MMIO TX FIFO responder.
package mmio_tx_fifo_pkg;

    typedef enum logic [1:0] {
        MMIO_OFF_DATA   = 2'd0,
        MMIO_OFF_STATUS = 2'd1,
        MMIO_OFF_THRESH = 2'd2,
        MMIO_OFF_CTRL   = 2'd3
    } mmio_off_e;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int CTRL_FLUSH       = 0;

    function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf,
                                                input logic full, input logic empty);
        logic [31:0] w;
        w = '0;
        w[STATUS_COUNT_LSB +: 8] = cnt;
        w[STATUS_OVF]            = ovf;
        w[STATUS_FULL]           = full;
        w[STATUS_EMPTY]          = empty;
        return w;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo_sync_fifo.sv
// Single-clock word FIFO with flush; head is a combinational peek of the oldest entry.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module mmio_tx_fifo_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   data_in,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW:0]   count_next,
    output logic [31:0]   head
);

    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Flush outranks everything; a pop frees the slot a same-cycle push needs.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + CNT_ONE;
        else if (do_pop && !do_push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push)
            mem[wr_ptr] <= data_in;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mmio_tx_fifo.sv
// CPU-store-fed TX FIFO on the data-memory port, drained by a valid/ready sink.
// Optional MMIO_FIFO_IRQ_EN adds a registered drain-to-threshold interrupt output.
module mmio_tx_fifo
    import mmio_tx_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_in,
    output logic [31:0] dm_data_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
`ifdef MMIO_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic          sel;
    logic          wr;
    mmio_off_e     off;
    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [31:0]   head;
    logic          ovf;
    logic [7:0]    thresh;
    logic [7:0]    count8;
    logic          unused_addr_bits;

    assign sel   = (dm_addr[31:4] == BASE_ADDR[31:4]);
    assign off   = mmio_off_e'(dm_addr[3:2]);
    assign wr    = sel && dm_write;
    assign push  = wr && (off == MMIO_OFF_DATA);
    assign flush = wr && (off == MMIO_OFF_CTRL) && dm_data_in[CTRL_FLUSH];
    assign pop   = out_valid && out_ready;
    assign unused_addr_bits = ^dm_addr[1:0];

    mmio_tx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .data_in    (dm_data_in),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .count_next (count_next),
        .head       (head)
    );

    assign out_valid = !empty;
    assign out_data  = head;
    assign count8    = 8'(count);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf    <= 1'b0;
            thresh <= '0;
        end else begin
            if (wr && off == MMIO_OFF_STATUS)
                ovf <= 1'b0;
            else if (push && full && !pop)
                ovf <= 1'b1;
            if (wr && off == MMIO_OFF_THRESH)
                thresh <= dm_data_in[7:0];
        end
    end

    always_comb begin
        dm_data_out = '0;
        if (sel) begin
            unique case (off)
                MMIO_OFF_DATA:   dm_data_out = head;
                MMIO_OFF_STATUS: dm_data_out = status_word(count8, ovf, full, empty);
                MMIO_OFF_THRESH: dm_data_out = {24'b0, thresh};
                MMIO_OFF_CTRL:   dm_data_out = '0;
            endcase
        end
    end

`ifdef MMIO_FIFO_IRQ_EN
    // Compares the post-update occupancy so irq tracks count without an extra cycle of lag.
    always_ff @(posedge clk) begin
        if (!rst)
            irq <= 1'b0;
        else
            irq <= (8'(count_next) <= thresh) && (thresh != 8'd0);
    end
`else
    logic unused_count_next;
    assign unused_count_next = ^count_next;
`endif

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Bench for mmio_tx_fifo: queue-based reference model compared every cycle, plus directed
// literal checks. Define MMIO_FIFO_IRQ_EN to also exercise the irq output.
module tb_mmio_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_in;
    logic [31:0] dm_data_out;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef MMIO_FIFO_IRQ_EN
    logic        irq;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mmio_tx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .dm_write    (dm_write),
        .dm_addr     (dm_addr),
        .dm_data_in  (dm_data_in),
        .dm_data_out (dm_data_out),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef MMIO_FIFO_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    // Reference model: the FIFO is just a queue of words.
    logic [31:0] q[$];
    logic        m_ovf;
    logic [7:0]  m_thresh;
    logic        m_irq;
    logic        m_live = 1'b0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:4] == 28'h000_0010) begin
            case (a[3:2])
                2'd0: r = (q.size() != 0) ? q[0] : 32'h0;
                2'd1: r = {16'h0, 8'(q.size()), 5'b0, m_ovf, q.size() == 8, q.size() == 0};
                2'd2: r = {24'h0, m_thresh};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic       pop_now;
        logic       hit;
        logic       do_push;
        logic       do_flush;
        logic [7:0] new_thresh;
        if (!rst) begin
            q.delete();
            m_ovf    = 1'b0;
            m_thresh = 8'h0;
            m_irq    = 1'b0;
            m_live   = 1'b1;
        end else begin
            pop_now    = (q.size() != 0) && out_ready;
            hit        = dm_write && (dm_addr[31:4] == 28'h000_0010);
            do_push    = 1'b0;
            do_flush   = 1'b0;
            new_thresh = m_thresh;
            if (hit) begin
                case (dm_addr[3:2])
                    2'd0: if (q.size() < 8 || pop_now) do_push = 1'b1; else m_ovf = 1'b1;
                    2'd1: m_ovf = 1'b0;
                    2'd2: new_thresh = dm_data_in[7:0];
                    default: do_flush = dm_data_in[0];
                endcase
            end
            if (do_flush) begin
                q.delete();
            end else begin
                if (pop_now) void'(q.pop_front());
                if (do_push) q.push_back(dm_data_in);
            end
            m_irq    = (q.size() <= int'(m_thresh)) && (m_thresh != 0);
            m_thresh = new_thresh;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("cmp_out_data", out_data, (q.size() != 0) ? q[0] : 32'h0);
            check("cmp_dm_data_out", dm_data_out, m_read(dm_addr));
`ifdef MMIO_FIFO_IRQ_EN
            check("cmp_irq", {31'b0, irq}, {31'b0, m_irq});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dm_write   = 1'b1;
        dm_addr    = a;
        dm_data_in = d;
        tick();
        dm_write   = 1'b0;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        dm_addr = a;
        #1;
        check(name, dm_data_out, exp);
    endtask

    initial begin
        rst = 1'b0; dm_write = 1'b0; dm_addr = 32'h0; dm_data_in = 32'h0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        peek("reset_status", 32'h104, 32'h0000_0001);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
`ifdef MMIO_FIFO_IRQ_EN
        check("reset_irq", {31'b0, irq}, 32'h0);
`endif

        // Single push, visible next cycle.
        store(32'h100, 32'hDEAD_BEEF);
        check("push_out_valid", {31'b0, out_valid}, 32'h1);
        check("push_out_data", out_data, 32'hDEAD_BEEF);
        peek("push_status", 32'h104, 32'h0000_0100);
        peek("push_data_read", 32'h100, 32'hDEAD_BEEF);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Overflow: nine stores into eight slots.
        for (int i = 1; i <= 9; i++) store(32'h100, i);
        peek("ovf_status", 32'h104, 32'h0000_0806);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", out_data, i);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", {31'b0, out_valid}, 32'h0);
        store(32'h104, 32'h0);
        peek("ovf_cleared", 32'h104, 32'h0000_0001);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) store(32'h100, 32'h11 + i);
        out_ready = 1'b1;
        store(32'h100, 32'hA5);
        out_ready = 1'b0;
        peek("full_pushpop_status", 32'h104, 32'h0000_0802);
        check("full_pushpop_head", out_data, 32'h12);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("full_pushpop_last", out_data, 32'hA5);
        tick();
        out_ready = 1'b0;
        check("full_pushpop_empty", {31'b0, out_valid}, 32'h0);

        // Flush beats a same-cycle pop.
        for (int i = 0; i < 3; i++) store(32'h100, 32'h30 + i);
        out_ready = 1'b1;
        store(32'h10C, 32'h1);
        out_ready = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'h0);
        peek("flush_status", 32'h104, 32'h0000_0001);

        // Out-of-window store and reads.
        store(32'h200, 32'h55);
        peek("oow_read", 32'h200, 32'h0);
        peek("oow_status", 32'h104, 32'h0000_0001);

        // Reset mid-stream discards queued words.
        store(32'h100, 32'h77);
        store(32'h100, 32'h78);
        rst = 1'b0; tick(); rst = 1'b1;
        check("midreset_out_valid", {31'b0, out_valid}, 32'h0);

        // Threshold register and drain interrupt.
        store(32'h108, 32'h0000_1202);
        peek("thresh_read", 32'h108, 32'h0000_0002);
        for (int i = 0; i < 4; i++) store(32'h100, 32'h40 + i);
        peek("irq_fill_status", 32'h104, 32'h0000_0400);
`ifdef MMIO_FIFO_IRQ_EN
        check("irq_at_4", {31'b0, irq}, 32'h0);
`endif
        out_ready = 1'b1;
        tick();
`ifdef MMIO_FIFO_IRQ_EN
        check("irq_at_3", {31'b0, irq}, 32'h0);
`endif
        tick();
        out_ready = 1'b0;
        peek("irq_drain_status", 32'h104, 32'h0000_0200);
`ifdef MMIO_FIFO_IRQ_EN
        check("irq_at_2", {31'b0, irq}, 32'h1);
`endif
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
